mul_seq_ctrl: RTL
=================

Name: mul_seq_ctrl

Overview:
- Sequential shift-and-add multiplier controller.
- Reuses one WIDTH-bit ripple adder stage over WIDTH clock cycles instead of instantiating WIDTH-1 adder rows.
- Sits beside the combinational array multiplier as its area-reduced alternative, behind a start/busy/done handshake.
- Owns the FSM, iteration counter, and accumulator/multiplier shift register.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits; legal range 2..16.
- CNT_W, 3, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- start  input  1  request a new multiplication; sampled only in IDLE.
- a  input  WIDTH  multiplicand; captured on the accepted start edge.
- b  input  WIDTH  multiplier; captured on the accepted start edge.
- busy  output  1  high while an operation is in RUN or DONE.
- done  output  1  one-cycle pulse when mul holds a new valid product.
- mul  output  2*WIDTH  product register; unsigned a*b.

Behaviour:
- Reset values: busy=0, done=0, mul=0; FSM in IDLE; counter=0; internal registers=0.
- Reset is asynchronous and takes effect at any time, including mid-operation; the operation in progress is aborted and no done pulse is issued.
- States and transitions:
  - IDLE: if start=1 at a clock edge, latch a_r<=a, hold {acc[WIDTH:0], q[WIDTH-1:0]} <= {0, b}, cnt<=0, and go to RUN. Otherwise stay in IDLE.
  - RUN: each edge, compute sum = acc[WIDTH-1:0] + (q[0] ? a_r : 0) as WIDTH+1 bits, carry included. Then shift right by one: {acc,q} <= {1'b0, sum, q[WIDTH-1:1]}. cnt<=cnt+1. When cnt==WIDTH-1 on this edge, go to DONE.
  - DONE: mul <= {acc[WIDTH-1:0], q} was registered on the RUN->DONE edge. done=1 for this single cycle. Next edge goes to IDLE.
- RUN lasts exactly WIDTH cycles.
- Latency: start accepted on edge k; done is high during the cycle after edge k+WIDTH; mul is valid from that same cycle.
- busy is 1 in RUN and DONE, and 0 in IDLE. busy rises in the cycle after the accepted start.
- start while busy=1 (RUN or DONE) is ignored. There is no queueing, and a, b, and the result are unaffected. Back-to-back operation: start asserted in the cycle after done (IDLE) is accepted.
- mul holds the previous product during RUN and changes only on the RUN->DONE edge. It holds indefinitely in IDLE.
- a and b may change freely after the accepted start edge without effect.
- Width rule: the adder carry is kept as acc[WIDTH], so there is no overflow. The maximum product (2**WIDTH-1)**2 fits in 2*WIDTH bits.
- cnt never wraps during RUN; it is cleared on every accepted start.

Optional Feature:
- Macro MUL_SEQ_ZERO_SKIP_EN.
- Defined: in IDLE, an accepted start with a==0 or b==0 goes directly to DONE with mul<=0. done is high in the cycle after the start edge (latency 1), and busy is high for that one DONE cycle only.
- Undefined: zero operands take the full WIDTH-cycle RUN path like any other operands, and the result is still 0.

Test Plan:
- After reset, start with a=13, b=11 -> busy=1 for WIDTH+1=5 cycles; done pulses once, 5 cycles after the start edge; mul=8'h8F (143).
- a=15, b=15 -> mul=8'hE1 (225). Checks carry propagation into acc[WIDTH] on every step.
- a=0, b=9 -> mul=0. With MUL_SEQ_ZERO_SKIP_EN: done one cycle after start. Without it: done after 5 cycles, same as the 13x11 case.
- Start 6x7. Pulse start with a=2, b=2 at cycle 2 of RUN, and change a/b mid-RUN -> single done, mul=8'h2A (42); the second start is ignored.
- Start 9x9 and assert rst on cycle 3 of RUN -> busy, done, and mul drop to 0 immediately (before the next clock edge); no done pulse afterwards. A new 3x5 start then completes with mul=8'h0F.
- Back-to-back: 5x5 then 4x3, with start re-asserted the cycle after the first done -> mul=8'h19 then 8'h0C; mul holds 8'h19 throughout the second RUN.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-and-add multiplier: one WIDTH-bit adder reused for WIDTH cycles.
// Optional macro MUL_SEQ_ZERO_SKIP_EN: a zero operand bypasses RUN and completes in one cycle.
module mul_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   mul
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    // The carry bit of the accumulator is always shifted out as zero, so only
    // the low WIDTH bits need storage; the sum keeps the carry for each step.
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [2*WIDTH-1:0]   mul_q, mul_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH-1:0]     addend_s;

    // Next-state, datapath step and output-register computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        acc_d    = acc_q;
        q_d      = q_q;
        mul_d    = mul_q;
        addend_s = q_q[0] ? a_q : {WIDTH{1'b0}};
        sum_s    = {1'b0, acc_q} + {1'b0, addend_s};
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    acc_d   = {WIDTH{1'b0}};
                    q_d     = b;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = RUN;
`ifdef MUL_SEQ_ZERO_SKIP_EN
                    if ((a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}})) begin
                        state_d = DONE;
                        mul_d   = {(2*WIDTH){1'b0}};
                    end else begin
                        state_d = RUN;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = sum_s[WIDTH:1];
                q_d   = {sum_s[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    mul_d   = {sum_s[WIDTH:1], sum_s[0], q_q[WIDTH-1:1]};
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            q_q     <= {WIDTH{1'b0}};
            mul_q   <= {(2*WIDTH){1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            mul_q   <= mul_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign mul  = mul_q;

endmodule
